// File: rtl/mem_addr_seq.sv
// Registered memory-address sequencer: selects one of N_SRC address sources,
// latches it and runs a fixed-latency access with done/misalign pulses.
module mem_addr_seq #(
    parameter int WIDTH       = 32,
    parameter int N_SRC       = 8,
    parameter int SEL_W       = 3,
    parameter int WAIT_CYCLES = 1,
    parameter int ALIGN_CHECK = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SRC*WIDTH-1:0] src_flat,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   req,
    input  logic                   wr,
    input  logic                   word,
    output logic                   busy,
    output logic [WIDTH-1:0]       addr_out,
    output logic                   mem_en,
    output logic                   mem_wr,
    output logic                   done,
    output logic                   misalign
);

    localparam int          N_SLOT   = 1 << SEL_W;
    localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    state_t           state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [WIDTH-1:0] addr_reg, addr_next;
    logic             wr_reg, wr_next;

    logic [WIDTH-1:0] src_arr [N_SLOT];
    logic [WIDTH-1:0] src_sel;
    logic             unaligned;

    // Every select code maps to a slot; codes beyond N_SRC read as address 0.
    generate
        for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_src
            if (gi < N_SRC) begin : g_used
                assign src_arr[gi] = src_flat[gi*WIDTH +: WIDTH];
            end else begin : g_unused
                assign src_arr[gi] = '0;
            end
        end
    endgenerate

    assign src_sel   = src_arr[sel];
    assign unaligned = (ALIGN_CHECK != 0) && word && (src_sel[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wr_reg    <= wr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wr_next    = wr_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    addr_next = src_sel;
                    wr_next   = wr;
                    if (unaligned) begin
                        state_next = ERR;
                    end else begin
                        state_next = ACCESS;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            ACCESS: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // All outputs are pure state/register decode, so nothing combinational
    // reaches them from the inputs.
    assign busy     = (state_reg != IDLE);
    assign mem_en   = (state_reg == ACCESS);
    assign mem_wr   = wr_reg & mem_en;
    assign done     = (state_reg == DONE);
    assign misalign = (state_reg == ERR);
    assign addr_out = addr_reg;

endmodule

// File: tb/tb_mem_addr_seq.sv
// Bench for mem_addr_seq: scoreboarded 8-source/3-wait instance plus a
// directed 4-source, 16-bit, no-alignment-check instance.
module tb_mem_addr_seq;

    localparam int WAIT_A = 3;

    logic clk;
    logic reset;

    // instance A: WIDTH=32, N_SRC=8, WAIT=3, alignment check on
    logic [31:0]  src_a [8];
    logic [255:0] src_flat_a;
    logic [2:0]   sel_a;
    logic         req_a, wr_a, word_a;
    logic         busy_a, mem_en_a, mem_wr_a, done_a, misalign_a;
    logic [31:0]  addr_a;

    // instance B: WIDTH=16, N_SRC=4, WAIT=1, alignment check off
    logic [15:0]  src_b [4];
    logic [63:0]  src_flat_b;
    logic [1:0]   sel_b;
    logic         req_b, wr_b, word_b;
    logic         busy_b, mem_en_b, mem_wr_b, done_b, misalign_b;
    logic [15:0]  addr_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic mon_on = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic        err;
        int          n_en;
        logic        done_e;
        logic [31:0] addr_after;
        int          start;
    } exp_t;

    exp_t exp_q [$];

    always_comb begin
        src_flat_a = '0;
        for (int i = 0; i < 8; i++) src_flat_a[i*32 +: 32] = src_a[i];
    end

    always_comb begin
        src_flat_b = '0;
        for (int i = 0; i < 4; i++) src_flat_b[i*16 +: 16] = src_b[i];
    end

    mem_addr_seq #(
        .WIDTH(32), .N_SRC(8), .SEL_W(3), .WAIT_CYCLES(WAIT_A), .ALIGN_CHECK(1)
    ) dut_a (
        .clk(clk), .reset(reset), .src_flat(src_flat_a), .sel(sel_a),
        .req(req_a), .wr(wr_a), .word(word_a), .busy(busy_a),
        .addr_out(addr_a), .mem_en(mem_en_a), .mem_wr(mem_wr_a),
        .done(done_a), .misalign(misalign_a)
    );

    mem_addr_seq #(
        .WIDTH(16), .N_SRC(4), .SEL_W(2), .WAIT_CYCLES(1), .ALIGN_CHECK(0)
    ) dut_b (
        .clk(clk), .reset(reset), .src_flat(src_flat_b), .sel(sel_b),
        .req(req_b), .wr(wr_b), .word(word_b), .busy(busy_b),
        .addr_out(addr_b), .mem_en(mem_en_b), .mem_wr(mem_wr_b),
        .done(done_b), .misalign(misalign_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    task automatic push_exp(input logic w, input logic wd, input logic [31:0] a, input logic abort);
        exp_t e;
        e.addr       = a;
        e.wr         = w;
        e.err        = wd && (a[1:0] != 2'b00);
        e.n_en       = e.err ? 0 : (abort ? 2 : WAIT_A);
        e.done_e     = !e.err && !abort;
        e.addr_after = abort ? 32'h0 : a;
        e.start      = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (busy_a !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 32'(n < 40), 32'd1);
    endtask

    // Single request, then scramble every input so the access in flight
    // must rely on what was latched.
    task automatic access_a(input logic [2:0] s, input logic w, input logic wd,
                            input logic [31:0] a, input logic abort);
        wait_idle_a();
        src_a[s] = a;
        sel_a    = s;
        wr_a     = w;
        word_a   = wd;
        req_a    = 1'b1;
        push_exp(w, wd, a, abort);
        @(negedge clk);
        req_a    = 1'b0;
        src_a[s] = $urandom;
        sel_a    = 3'($urandom);
        wr_a     = ~w;
        word_a   = ~wd;
    endtask

    always begin : mon_a
        exp_t e;
        int   n;
        @(negedge clk);
        if (mon_on) begin
            if (mem_en_a || misalign_a) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_access", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn: addr=%08h wr=%0d err=%0d start=%0d", e.addr, e.wr, e.err, e.start);
                    chk("start_cycle", 32'(cyc), 32'(e.start));
                    chk("addr_latch", addr_a, e.addr);
                    chk("misalign", 32'(misalign_a), 32'(e.err));
                    chk("busy", 32'(busy_a), 32'd1);
                    chk("done_clear", 32'(done_a), 32'd0);
                    if (e.err) begin
                        chk("err_mem_en", 32'(mem_en_a), 32'd0);
                    end else begin
                        n = 0;
                        while (mem_en_a === 1'b1 && n < 20) begin
                            chk("mem_wr", 32'(mem_wr_a), 32'(e.wr));
                            chk("addr_hold", addr_a, e.addr);
                            n++;
                            @(negedge clk);
                        end
                        chk("en_cycles", 32'(n), 32'(e.n_en));
                        chk("done", 32'(done_a), 32'(e.done_e));
                        chk("addr_after", addr_a, e.addr_after);
                        chk("no_misalign", 32'(misalign_a), 32'd0);
                    end
                end
            end else begin
                chk("idle_no_done", 32'(done_a), 32'd0);
            end
        end
    end

    initial begin
        reset  = 1'b0;
        req_a  = 1'b1; req_b  = 1'b1;
        sel_a  = 3'd2; sel_b  = 2'd2;
        wr_a   = 1'b1; wr_b   = 1'b1;
        word_a = 1'b1; word_b = 1'b1;
        for (int i = 0; i < 8; i++) src_a[i] = 32'h1000 * (i + 1);
        for (int i = 0; i < 4; i++) src_b[i] = 16'(16'h0100 * (i + 1));

        // reset held for two edges with requests pending
        repeat (2) @(negedge clk);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_addr_a", addr_a, 32'd0);
        chk("rst_en_a", 32'({mem_en_a, mem_wr_a, done_a, misalign_a}), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        chk("rst_addr_b", 32'(addr_b), 32'd0);
        chk("rst_en_b", 32'({mem_en_b, mem_wr_b, done_b, misalign_b}), 32'd0);

        // instance B: single-wait word read of 0x40
        reset    = 1'b1;
        req_a    = 1'b0;
        mon_on   = 1'b1;
        src_b[2] = 16'h0040;
        sel_b    = 2'd2; word_b = 1'b1; wr_b = 1'b0; req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0; sel_b = 2'd0;
        chk("b_mem_en", 32'(mem_en_b), 32'd1);
        chk("b_addr", 32'(addr_b), 32'h40);
        chk("b_mem_wr", 32'(mem_wr_b), 32'd0);
        chk("b_done_early", 32'(done_b), 32'd0);
        @(negedge clk);
        chk("b_done", 32'(done_b), 32'd1);
        chk("b_en_off", 32'(mem_en_b), 32'd0);
        chk("b_busy_done", 32'(busy_b), 32'd1);
        @(negedge clk);
        chk("b_idle", 32'(busy_b), 32'd0);
        chk("b_done_end", 32'(done_b), 32'd0);

        // instance B: unaligned word write passes with the check disabled
        src_b[3] = 16'hFFFF;
        sel_b    = 2'd3; word_b = 1'b1; wr_b = 1'b1; req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0; sel_b = 2'd1; src_b[3] = 16'h1234;
        chk("b_no_misalign", 32'(misalign_b), 32'd0);
        chk("b_mem_en2", 32'(mem_en_b), 32'd1);
        chk("b_mem_wr2", 32'(mem_wr_b), 32'd1);
        chk("b_addr2", 32'(addr_b), 32'hFFFF);
        @(negedge clk);
        chk("b_done2", 32'(done_b), 32'd1);
        chk("b_no_misalign2", 32'(misalign_b), 32'd0);
        @(negedge clk);
        chk("b_addr_hold", 32'(addr_b), 32'hFFFF);
        chk("b_idle2", 32'(busy_b), 32'd0);

        // instance A: wait states, misalign, byte accesses
        access_a(3'd3, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
        access_a(3'd1, 1'b0, 1'b1, 32'h0000_0006, 1'b0);
        access_a(3'd1, 1'b0, 1'b0, 32'h0000_0006, 1'b0);
        access_a(3'd5, 1'b1, 1'b0, 32'd253, 1'b0);
        access_a(3'd6, 1'b0, 1'b0, 32'd254, 1'b0);
        access_a(3'd7, 1'b0, 1'b0, 32'd255, 1'b0);
        access_a(3'd0, 1'b0, 1'b1, 32'h0000_1000, 1'b0);
        access_a(3'd2, 1'b1, 1'b1, 32'h8000_0003, 1'b0);

        // req held high: one accept per IDLE visit, WAIT+2 apart
        wait_idle_a();
        req_a  = 1'b1;
        word_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel_a        = 3'(k * 2 + 1);
            src_a[sel_a] = 32'h2000 + 32'(k) * 32'd4;
            wr_a         = (k % 2 == 1);
            push_exp(wr_a, 1'b1, src_a[sel_a], 1'b0);
            @(negedge clk);
            sel_a = 3'($urandom);
            wr_a  = ~wr_a;
            repeat (WAIT_A + 1) @(negedge clk);
        end
        req_a = 1'b0;

        // reset during the second ACCESS cycle aborts the access
        access_a(3'd4, 1'b0, 1'b1, 32'h0000_0204, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_idle", 32'(busy_a), 32'd0);

        access_a(3'd2, 1'b1, 1'b1, 32'h0000_0040, 1'b0);

        repeat (10) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_addr_seq.md
Name: mem_addr_seq

Overview:
- Parametrised, registered successor to the CPU's memory-address source selector.
- Selects one of N_SRC address sources, latches it and drives a fixed-latency memory access of WAIT_CYCLES cycles, with a one-cycle completion pulse.
- Checks word alignment and flags a misaligned word access without touching memory.
- Sits between the control unit and the instruction/data memory port of the multicycle datapath.

Parameters:
- WIDTH, 32, address width in bits (>= 8).
- N_SRC, 8, number of address sources (2..16).
- SEL_W, 3, select width; must equal clog2(N_SRC).
- WAIT_CYCLES, 1, cycles mem_en stays asserted per access (1..15).
- ALIGN_CHECK, 1, 1 = enable word-alignment check; 0 = never flag misalign.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset: sampled on rising clk; 0 = reset.
- src_flat  in  N_SRC*WIDTH  packed sources; source i = src_flat[i*WIDTH +: WIDTH].
- sel  in  SEL_W  source index, sampled on accept.
- req  in  1  access request, sampled only in IDLE.
- wr  in  1  1 = write access, 0 = read; sampled on accept.
- word  in  1  1 = word access (alignment checked), 0 = byte; sampled on accept.
- busy  out  1  high in every state except IDLE.
- addr_out  out  WIDTH  latched address; holds its value between accepts.
- mem_en  out  1  memory enable, high during ACCESS only.
- mem_wr  out  1  write strobe = latched wr AND mem_en.
- done  out  1  one-cycle pulse at the end of a successful access.
- misalign  out  1  one-cycle pulse for a rejected misaligned word access.

Behaviour:
- Reset (reset=0 at an edge): state IDLE; addr_out=0; mem_en, mem_wr, done, misalign, busy = 0; counter = 0. Takes priority over everything and aborts any access in progress at that same edge.
- States: IDLE, ACCESS, DONE, ERR.
- IDLE, req=1 at edge T (accept):
  - addr_out <= src[sel]; latch wr.
  - If ALIGN_CHECK=1, word=1 and src[sel][1:0]!=0: go to ERR.
  - Otherwise go to ACCESS and load counter with WAIT_CYCLES-1.
- sel >= N_SRC on accept: addr_out <= 0, access proceeds normally; no error is flagged.
- ACCESS:
  - mem_en=1, mem_wr=latched wr.
  - Counter decrements each cycle; at counter==0, go to DONE.
  - mem_en is therefore high for exactly WAIT_CYCLES cycles, from T+1 through T+WAIT_CYCLES.
- DONE: done=1 for one cycle (cycle T+WAIT_CYCLES+1), mem_en=0, then IDLE.
- ERR: misalign=1 for one cycle (cycle T+1), mem_en=0, then IDLE. addr_out shows the offending address.
- Earliest next accept: edge T+WAIT_CYCLES+2 (success) or T+2 (error). Back-to-back requests get no bypass.
- req while busy is ignored and not queued. sel, wr, word and src changes after accept do not affect the access in flight.
- Outputs come directly from registers or state decode; no combinational path from inputs to outputs.
- Byte accesses (word=0) are never flagged, e.g. exception vector addresses 253/254/255.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req=1 -> all outputs 0, busy=0. Release, req=1, sel=2, src2=0x0000_0040, word=1, wr=0, WAIT_CYCLES=1 -> mem_en=1 at T+1 with addr_out=0x40, mem_wr=0, done=1 at T+2, busy=0 at T+3.
- Wait states (WAIT_CYCLES=3): write request, sel=3, src3=0x100 -> mem_en=mem_wr=1 for exactly 3 cycles, done on the 4th, addr_out stays 0x100 afterwards.
- Misalign: word=1, src1=0x0000_0006 -> misalign=1 at T+1, mem_en never asserted, addr_out=0x6. Same address with word=0 -> normal access, done pulse.
- Busy ignore: req held high continuously and sel changed mid-access -> exactly one access per IDLE visit, addresses match sel at each accept, spacing = WAIT_CYCLES+2 cycles.
- Reset mid-access (WAIT_CYCLES=4): reset=0 during the 2nd ACCESS cycle -> next edge mem_en=0, addr_out=0, no done pulse.
- Parametrisation: N_SRC=4, SEL_W=2, WIDTH=16, ALIGN_CHECK=0, sel=3, src3=0xFFFF with word=1 -> no misalign, addr_out=0xFFFF, done pulse.
